// File: rtl/gradient_magnitude_direction.sv
// Gradient magnitude (|Gx|+|Gy|, shifted and saturated) and 2-bit quantised direction,
// with frame-structure tagging (sof/eol/eof) and a sticky frame error, 3-cycle latency.
module gradient_magnitude_direction #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MAG_SHIFT  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [31:0]           i_Gx_Gy_vector,
  input  logic                  i_data_valid,
  input  logic                  i_start_of_frame,
  output logic [DATA_WIDTH-1:0] o_magnitude,
  output logic [1:0]            o_direction,
  output logic                  o_data_valid,
  output logic                  o_start_of_frame,
  output logic                  o_end_of_line,
  output logic                  o_end_of_frame,
  output logic                  o_frame_error
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  localparam logic [1:0] DIR_0   = 2'd0;
  localparam logic [1:0] DIR_45  = 2'd1;
  localparam logic [1:0] DIR_90  = 2'd2;
  localparam logic [1:0] DIR_135 = 2'd3;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t          r_state, w_stateNext;
  logic [CW-1:0]   r_col, w_colNext, w_beatCol;
  logic [RW-1:0]   r_row, w_rowNext, w_beatRow;
  logic            w_accept, w_isEol, w_isEof, w_errEvent;
  logic            r_frameError;

  logic [15:0]     w_gx, w_gy, w_absGx, w_absGy;
  logic            w_sgnSame;

  logic            r1_valid, r1_sof, r1_eol, r1_eof, r1_sgnSame;
  logic [15:0]     r1_absGx, r1_absGy;

  logic [25:0]     w_gyScaled, w_gxLow, w_gxHigh;
  logic [16:0]     w_magRaw;
  logic [1:0]      w_dir;

  logic            r2_valid, r2_sof, r2_eol, r2_eof;
  logic [16:0]     r2_magRaw;
  logic [1:0]      r2_dir;

  logic [16:0]           w_shifted;
  logic [DATA_WIDTH-1:0] w_magSat;

  logic                  r3_valid, r3_sof, r3_eol, r3_eof;
  logic [DATA_WIDTH-1:0] r3_mag;
  logic [1:0]            r3_dir;

  function automatic logic [15:0] absSat(input logic [15:0] v);
    if (!v[15])             return v;
    else if (v == 16'h8000) return 16'h7FFF;
    else                    return 16'(-v);
  endfunction

  // A sof beat always restarts the position counters, whether it opens or interrupts a frame.
  always_comb begin
    w_stateNext = r_state;
    w_colNext   = r_col;
    w_rowNext   = r_row;
    w_beatCol   = i_start_of_frame ? '0 : r_col;
    w_beatRow   = i_start_of_frame ? '0 : r_row;
    w_accept    = i_data_valid & (i_start_of_frame | (r_state == S_ACTIVE));
    w_errEvent  = i_data_valid & (i_start_of_frame ? (r_state == S_ACTIVE) : (r_state == S_IDLE));
    w_isEol     = (w_beatCol == COL_LAST);
    w_isEof     = w_isEol & (w_beatRow == ROW_LAST);
    if (w_accept) begin
      if (w_isEol) begin
        w_colNext = '0;
        w_rowNext = w_isEof ? '0 : w_beatRow + RW'(1);
      end else begin
        w_colNext = w_beatCol + CW'(1);
        w_rowNext = w_beatRow;
      end
      w_stateNext = w_isEof ? S_IDLE : S_ACTIVE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_frameError <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_col        <= w_colNext;
      r_row        <= w_rowNext;
      r_frameError <= r_frameError | w_errEvent;
    end
  end

  assign w_gx      = i_Gx_Gy_vector[15:0];
  assign w_gy      = i_Gx_Gy_vector[31:16];
  assign w_absGx   = absSat(w_gx);
  assign w_absGy   = absSat(w_gy);
  assign w_sgnSame = ((!w_gx[15] && (w_gx != '0)) && (!w_gy[15] && (w_gy != '0))) ||
                     (w_gx[15] && w_gy[15]);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r1_valid   <= 1'b0;
      r1_sof     <= 1'b0;
      r1_eol     <= 1'b0;
      r1_eof     <= 1'b0;
      r1_sgnSame <= 1'b0;
      r1_absGx   <= '0;
      r1_absGy   <= '0;
    end else begin
      r1_valid <= w_accept;
      r1_sof   <= w_accept & i_start_of_frame;
      r1_eol   <= w_accept & w_isEol;
      r1_eof   <= w_accept & w_isEof;
      if (w_accept) begin
        r1_absGx   <= w_absGx;
        r1_absGy   <= w_absGy;
        r1_sgnSame <= w_sgnSame;
      end
    end
  end

  // Thresholds 106/256 and 618/256 approximate tan(22.5) and tan(67.5).
  assign w_gyScaled = {2'b00, r1_absGy, 8'h00};
  assign w_gxLow    = 26'(r1_absGx) * 26'd106;
  assign w_gxHigh   = 26'(r1_absGx) * 26'd618;
  assign w_magRaw   = {1'b0, r1_absGx} + {1'b0, r1_absGy};

  always_comb begin
    w_dir = DIR_0;
    if ((r1_absGx == '0) && (r1_absGy == '0)) w_dir = DIR_0;
    else if (w_gyScaled < w_gxLow)            w_dir = DIR_0;
    else if (w_gyScaled > w_gxHigh)           w_dir = DIR_90;
    else                                      w_dir = r1_sgnSame ? DIR_45 : DIR_135;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r2_valid  <= 1'b0;
      r2_sof    <= 1'b0;
      r2_eol    <= 1'b0;
      r2_eof    <= 1'b0;
      r2_magRaw <= '0;
      r2_dir    <= '0;
    end else begin
      r2_valid <= r1_valid;
      r2_sof   <= r1_sof;
      r2_eol   <= r1_eol;
      r2_eof   <= r1_eof;
      if (r1_valid) begin
        r2_magRaw <= w_magRaw;
        r2_dir    <= w_dir;
      end
    end
  end

  assign w_shifted = r2_magRaw >> MAG_SHIFT;

  generate
    if (DATA_WIDTH >= 17) begin : g_noSat
      assign w_magSat = DATA_WIDTH'(w_shifted);
    end else begin : g_sat
      assign w_magSat = (|w_shifted[16:DATA_WIDTH]) ? '1 : w_shifted[DATA_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r3_valid <= 1'b0;
      r3_sof   <= 1'b0;
      r3_eol   <= 1'b0;
      r3_eof   <= 1'b0;
      r3_mag   <= '0;
      r3_dir   <= '0;
    end else begin
      r3_valid <= r2_valid;
      r3_sof   <= r2_sof;
      r3_eol   <= r2_eol;
      r3_eof   <= r2_eof;
      if (r2_valid) begin
        r3_mag <= w_magSat;
        r3_dir <= r2_dir;
      end
    end
  end

  assign o_magnitude      = r3_mag;
  assign o_direction      = r3_dir;
  assign o_data_valid     = r3_valid;
  assign o_start_of_frame = r3_sof;
  assign o_end_of_line    = r3_eol;
  assign o_end_of_frame   = r3_eof;
  assign o_frame_error    = r_frameError;

endmodule

// File: tb/tb_gradient_magnitude_direction.sv
// Scoreboard bench: two 4x2-frame instances (MAG_SHIFT 0 and 5) driven with directed vectors;
// a negedge monitor pops expected beats and checks value, tags and arrival cycle.
module tb_gradient_magnitude_direction;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int IH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [1:0][31:0]     vec;
  logic [1:0]           valid, sof;
  logic [1:0][DW-1:0]   mag;
  logic [1:0][1:0]      dir;
  logic [1:0]           oValid, oSof, oEol, oEof, oErr;

  typedef struct {
    int cyc;
    int mag;
    int dir;
    bit sof;
    bit eol;
    bit eof;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t monE;
  int   checks = 0;
  int   errors = 0;
  int   cycCount = 0;
  bit   monitorOn = 1'b0;

  gradient_magnitude_direction #(
    .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .MAG_SHIFT(0)
  ) u_dutA (
    .i_clk(clk), .i_reset(reset), .i_Gx_Gy_vector(vec[0]),
    .i_data_valid(valid[0]), .i_start_of_frame(sof[0]),
    .o_magnitude(mag[0]), .o_direction(dir[0]), .o_data_valid(oValid[0]),
    .o_start_of_frame(oSof[0]), .o_end_of_line(oEol[0]), .o_end_of_frame(oEof[0]),
    .o_frame_error(oErr[0])
  );

  gradient_magnitude_direction #(
    .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .MAG_SHIFT(5)
  ) u_dutB (
    .i_clk(clk), .i_reset(reset), .i_Gx_Gy_vector(vec[1]),
    .i_data_valid(valid[1]), .i_start_of_frame(sof[1]),
    .o_magnitude(mag[1]), .o_direction(dir[1]), .o_data_valid(oValid[1]),
    .o_start_of_frame(oSof[1]), .o_end_of_line(oEol[1]), .o_end_of_frame(oEof[1]),
    .o_frame_error(oErr[1])
  );

  always @(posedge clk) cycCount <= cycCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One beat; when push is set the expected output is queued for 3 cycles later.
  task automatic applyStimulus(input int sel, input int gx, input int gy, input bit isSof,
                               input bit push, input int expMag, input int expDir,
                               input bit expEol, input bit expEof);
    exp_t e;
    vec[sel]   = {gy[15:0], gx[15:0]};
    valid[sel] = 1'b1;
    sof[sel]   = isSof;
    if (push) begin
      e.cyc = cycCount + 3;
      e.mag = expMag;
      e.dir = expDir;
      e.sof = isSof;
      e.eol = expEol;
      e.eof = expEof;
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
    @(posedge clk);
    #1;
    valid[sel] = 1'b0;
    sof[sel]   = 1'b0;
    vec[sel]   = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (monitorOn) begin
      for (int s = 0; s < 2; s++) begin
        if (oValid[s]) begin
          if ((s == 0 ? q0.size() : q1.size()) == 0) begin
            checkOutput($sformatf("dut%0d unexpectedBeat", s), oValid[s], 0);
          end else begin
            if (s == 0) monE = q0.pop_front();
            else        monE = q1.pop_front();
            checkOutput($sformatf("dut%0d cycle", s), cycCount, monE.cyc);
            checkOutput($sformatf("dut%0d magnitude", s), mag[s], monE.mag);
            checkOutput($sformatf("dut%0d direction", s), dir[s], monE.dir);
            checkOutput($sformatf("dut%0d sof", s), oSof[s], monE.sof);
            checkOutput($sformatf("dut%0d eol", s), oEol[s], monE.eol);
            checkOutput($sformatf("dut%0d eof", s), oEof[s], monE.eof);
          end
        end else begin
          checkOutput($sformatf("dut%0d tagsWithoutValid", s), {oSof[s], oEol[s], oEof[s]}, 0);
        end
      end
    end
  end

  int gxT[8]  = '{100, -50,  50,   30, 0, 3000, -32768,  7};
  int gyT[8]  = '{  0, -50, -50, -200, 0, 2000,      0, -3};
  int magT[8] = '{100, 100, 100,  230, 0,  255,    255, 10};
  int dirT[8] = '{  0,   1,   3,    2, 0,    1,      0,  3};
  int gapT[8] = '{  0,   2,   1,    3, 0,    1,      2,  0};

  initial begin
    int waitCyc;
    reset = 1'b1;
    vec   = '0;
    valid = '0;
    sof   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("resetValid", oValid[0], 0);
    checkOutput("resetMagnitude", mag[0], 0);
    checkOutput("resetDirection", dir[0], 0);
    checkOutput("resetFrameError", oErr[0], 0);
    checkOutput("resetValidB", oValid[1], 0);
    monitorOn = 1'b1;

    $display("[TB] full frame with gaps");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, gxT[i], gyT[i], i == 0, 1, magT[i], dirT[i], (i % 4) == 3, i == 7);
      idle(gapT[i]);
    end
    idle(6);
    checkOutput("frameErrClean", oErr[0], 0);

    $display("[TB] beats without sof, then premature sof");
    applyStimulus(0, 10, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 20, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    checkOutput("frameErrSet", oErr[0], 1);
    for (int i = 0; i < 5; i++)
      applyStimulus(0, gxT[i], gyT[i], i == 0, 1, magT[i], dirT[i], i == 3, 0);
    for (int i = 0; i < 8; i++)
      applyStimulus(0, gxT[i], gyT[i], i == 0, 1, magT[i], dirT[i], (i % 4) == 3, i == 7);
    idle(6);
    checkOutput("frameErrSticky", oErr[0], 1);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 100, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, -50, -50, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5);
    checkOutput("postResetValid", oValid[0], 0);
    checkOutput("postResetMagnitude", mag[0], 0);
    checkOutput("postResetDirection", dir[0], 0);
    checkOutput("postResetFrameError", oErr[0], 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, gxT[i], gyT[i], i == 0, 1, magT[i], dirT[i], (i % 4) == 3, i == 7);
      idle(gapT[7 - i]);
    end
    idle(6);
    checkOutput("frameErrAfterGoodFrame", oErr[0], 0);

    $display("[TB] MAG_SHIFT=5 instance");
    applyStimulus(1, 3000, 2000, 1, 1, 156, 1, 0, 0);
    applyStimulus(1, -32768, 0, 0, 1, 255, 0, 0, 0);
    applyStimulus(1, 100, 0, 0, 1, 3, 0, 0, 0);
    applyStimulus(1, -200, -100, 0, 1, 9, 1, 1, 0);
    idle(6);

    waitCyc = 0;
    while (((q0.size() + q1.size()) != 0) && (waitCyc < 50)) begin
      idle(1);
      waitCyc++;
    end
    checkOutput("queueDrained", q0.size() + q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gradient_magnitude_direction.md
Name: gradient_magnitude_direction

Overview:
Downstream stage of the 5x5 Prewitt Gx/Gy processing block. Consumes the packed signed Gx/Gy vector with its valid and start-of-frame strobes. Produces a saturated gradient magnitude (|Gx|+|Gy|) and a 2-bit quantised edge direction per pixel, plus end-of-line and end-of-frame markers and a sticky frame-structure error flag, for the following non-maximum-suppression stage.

Parameters:
DATA_WIDTH, 8, width of the output magnitude (unsigned).
IMG_WIDTH, 640, active pixels per line.
IMG_HEIGHT, 480, active lines per frame.
MAG_SHIFT, 0, right shift applied to the 17-bit raw magnitude before saturation (0..16).

Ports:
i_clk  in  1  clock.
i_reset  in  1  synchronous, active-high reset.
i_Gx_Gy_vector  in  32  [15:0] = Gx, [31:16] = Gy, each two's-complement signed.
i_data_valid  in  1  pixel beat valid.
i_start_of_frame  in  1  first pixel of frame; qualified by i_data_valid.
o_magnitude  out  DATA_WIDTH  saturated (|Gx|+|Gy|) >> MAG_SHIFT.
o_direction  out  2  0 = 0 deg, 1 = 45 deg, 2 = 90 deg, 3 = 135 deg.
o_data_valid  out  1  output beat valid.
o_start_of_frame  out  1  aligned with first output beat of frame.
o_end_of_line  out  1  aligned with last beat of each line.
o_end_of_frame  out  1  aligned with last beat of frame.
o_frame_error  out  1  sticky frame-structure error.

Behaviour:
- One clock (i_clk). Reset is synchronous and active-high (i_reset). All outputs are 0 on reset. Pipeline valids and counters are cleared, FSM goes to IDLE.
- No backpressure. One beat per cycle max. Latency is exactly 3 cycles from accepted input beat to output beat. Gaps in i_data_valid are preserved one-for-one.
- Stage 1 registers:
  - |Gx| and |Gy| as 16-bit unsigned; abs(-32768) saturates to 32767.
  - sgn_same = (Gx>0 and Gy>0) or (Gx<0 and Gy<0).
  - Frame flags decided by the input FSM.
- Stage 2:
  - mag_raw = |Gx|+|Gy|, 17 bits, no overflow.
  - Direction, integer compare only:
    - |Gy|*256 < |Gx|*106 -> 0.
    - else |Gy|*256 > |Gx|*618 -> 2.
    - else sgn_same -> 1, otherwise 3.
  - Gx=Gy=0 gives direction 0. Gx=0 with Gy!=0 gives 2.
- Stage 3: m = mag_raw >> MAG_SHIFT; o_magnitude = (m > 2^DATA_WIDTH-1) ? all-ones : m.
- Input FSM, two states:
  - IDLE:
    - valid & sof -> ACTIVE, col=1, row=0; beat is emitted with sof.
    - valid & !sof -> beat dropped (never reaches output), o_frame_error set.
  - ACTIVE, on valid:
    - col==IMG_WIDTH-1: beat tagged EOL, col=0, row++.
    - If additionally row==IMG_HEIGHT-1: beat tagged EOF, FSM -> IDLE, row=0.
    - valid & sof while ACTIVE (premature frame): o_frame_error set; counters restart as for a new frame (col=1,row=0); beat emitted with sof.
  - IMG_WIDTH=1: every beat is EOL. IMG_WIDTH=IMG_HEIGHT=1: sof, eol and eof on the same beat; FSM returns to IDLE.
- sof/eol/eof are only asserted together with o_data_valid.
- o_frame_error is sticky; cleared only by i_reset.
- Reset mid-frame: in-flight beats are discarded, no partial output after reset, FSM back to IDLE.
- Counter widths are clog2(IMG_WIDTH) and clog2(IMG_HEIGHT), minimum 1.

Test Plan:
- Gx=100, Gy=0, single beat after sof -> 3 cycles later o_magnitude=100, o_direction=0, o_start_of_frame=1, o_data_valid=1.
- Gx=-50, Gy=-50 -> mag 100, dir 1. Gx=50, Gy=-50 -> mag 100, dir 3. Gx=30, Gy=-200 -> mag 230, dir 2. Gx=0, Gy=0 -> mag 0, dir 0.
- Gx=3000, Gy=2000, MAG_SHIFT=0 -> mag 255 (saturated), dir 1. Same input with MAG_SHIFT=5 -> mag 156. Gx=-32768, Gy=0 -> mag 255, no wrap.
- IMG_WIDTH=4, IMG_HEIGHT=2, 8 beats with random 0-3 cycle gaps -> eol on output beats 3 and 7, eof on beat 7, output gap pattern identical to input, o_frame_error stays 0.
- IMG_WIDTH=4, IMG_HEIGHT=2, two valid beats without sof -> no output beats, o_frame_error=1. Then sof after 5 beats of a frame -> new sof beat emitted, o_frame_error stays 1, counters restart.
- i_reset pulsed 1 cycle after 2 beats of a frame -> no output beats afterwards, all outputs 0. Next sof frame completes normally with correct eol/eof.
